// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// M-stage memory access unit with an M/W pipeline register. Decodes the MIPS
// load/store opcode in instr_m, runs one bus transaction per memory op through
// an IDLE -> BUSY -> DONE handshake, stalls the upstream pipeline while the
// access is outstanding, and extends load data into dr_w.
//
// Ports
//   clk, clr_n                : clock (rising edge) and async active-low reset
//   instr_m, ao_m, v2_m,
//   a3_m, res_m, pc8_m        : M-stage pipeline register contents
//   bus_req/we/addr/be/wdata  : registered bus master request outputs
//   bus_ack, bus_rdata        : bus slave response
//   stall_m                   : freeze upstream registers (combinational)
//   instr_w, a3_w, res_w,
//   pc8_w, ao_w, dr_w         : W-stage register outputs
//   exc_adel, exc_ades        : misaligned load / store (combinational)
//
// Configuration
//   MEM_ALIGN_CHECK_EN : when defined, misaligned word/half ops skip the bus
//                        and raise exc_adel/exc_ades; when undefined the low
//                        address bits are ignored and every op is aligned.
// -----------------------------------------------------------------------------
module mem_access_unit (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [31:0] instr_m,
  input  logic [31:0] ao_m,
  input  logic [31:0] v2_m,
  input  logic [4:0]  a3_m,
  input  logic [2:0]  res_m,
  input  logic [31:0] pc8_m,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall_m,
  output logic [31:0] instr_w,
  output logic [4:0]  a3_w,
  output logic [2:0]  res_w,
  output logic [31:0] pc8_w,
  output logic [31:0] ao_w,
  output logic [31:0] dr_w,
  output logic        exc_adel,
  output logic        exc_ades
);

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] instr_w_q, instr_w_d;
  logic [4:0]  a3_w_q, a3_w_d;
  logic [2:0]  res_w_q, res_w_d;
  logic [31:0] pc8_w_q, pc8_w_d;
  logic [31:0] ao_w_q, ao_w_d;
  logic [31:0] dr_w_q, dr_w_d;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [5:0] opcode;
  logic       is_lw, is_lh, is_lhu, is_lb, is_lbu, is_sw, is_sh, is_sb;
  logic       is_load, is_store, is_mem, misaligned, start;

  assign opcode   = instr_m[31:26];
  assign is_lw    = (opcode == OP_LW);
  assign is_lh    = (opcode == OP_LH);
  assign is_lhu   = (opcode == OP_LHU);
  assign is_lb    = (opcode == OP_LB);
  assign is_lbu   = (opcode == OP_LBU);
  assign is_sw    = (opcode == OP_SW);
  assign is_sh    = (opcode == OP_SH);
  assign is_sb    = (opcode == OP_SB);
  assign is_load  = is_lw | is_lh | is_lhu | is_lb | is_lbu;
  assign is_store = is_sw | is_sh | is_sb;
  assign is_mem   = is_load | is_store;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = ((is_lw | is_sw) & (ao_m[1:0] != 2'b00)) |
                      ((is_lh | is_lhu | is_sh) & ao_m[0]);
`else
  assign misaligned = 1'b0;
`endif

  // A bus access starts only from IDLE; the same op is still in M during
  // DONE (upstream frozen) and must not be re-issued.
  assign start    = (state_q == ST_IDLE) & is_mem & ~misaligned;
  assign stall_m  = (state_q == ST_BUSY) | start;
  assign exc_adel = (state_q == ST_IDLE) & is_load  & misaligned;
  assign exc_ades = (state_q == ST_IDLE) & is_store & misaligned;

  // ---------------------------------------------------------------------------
  // Byte lanes for the request
  // ---------------------------------------------------------------------------
  logic [3:0]  be_m;
  logic [31:0] wdata_m;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    be_m    = 4'b1111;
    wdata_m = v2_m;
    if (is_sh) begin
      be_m    = 4'b0011 << {ao_m[1], 1'b0};
      wdata_m = {2{v2_m[15:0]}};
    end else if (is_sb) begin
      be_m    = 4'b0001 << ao_m[1:0];
      wdata_m = {4{v2_m[7:0]}};
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM and bus request registers
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_BUSY;
          bus_req_d   = 1'b1;
          bus_we_d    = is_store;
          bus_addr_d  = {ao_m[31:2], 2'b00};
          bus_be_d    = be_m;
          bus_wdata_d = wdata_m;
        end
      end
      ST_BUSY: begin
        if (bus_ack) begin
          state_d   = ST_DONE;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          rdata_d   = bus_rdata;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load extension: ao_m here is exactly what lands in ao_w at the same edge.
  // ---------------------------------------------------------------------------
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;

  always_comb begin
    case (ao_m[1:0])
      2'd0:    load_byte = rdata_q[7:0];
      2'd1:    load_byte = rdata_q[15:8];
      2'd2:    load_byte = rdata_q[23:16];
      default: load_byte = rdata_q[31:24];
    endcase
    load_half = ao_m[1] ? rdata_q[31:16] : rdata_q[15:0];
    load_ext  = '0;
    if (is_lw)  load_ext = rdata_q;
    if (is_lb)  load_ext = {{24{load_byte[7]}}, load_byte};
    if (is_lbu) load_ext = {24'b0, load_byte};
    if (is_lh)  load_ext = {{16{load_half[15]}}, load_half};
    if (is_lhu) load_ext = {16'b0, load_half};
  end

  // ---------------------------------------------------------------------------
  // M/W pipeline register: bubble while stalled, otherwise advance.
  // Load data is only valid in DONE; loads that skip the bus carry dr_w = 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    instr_w_d = '0;
    a3_w_d    = '0;
    res_w_d   = '0;
    pc8_w_d   = '0;
    ao_w_d    = '0;
    dr_w_d    = '0;
    if (!stall_m) begin
      instr_w_d = instr_m;
      a3_w_d    = a3_m;
      res_w_d   = res_m;
      pc8_w_d   = pc8_m;
      ao_w_d    = ao_m;
      dr_w_d    = (state_q == ST_DONE) ? load_ext : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= ST_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      instr_w_q   <= '0;
      a3_w_q      <= '0;
      res_w_q     <= '0;
      pc8_w_q     <= '0;
      ao_w_q      <= '0;
      dr_w_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values,
      // independent of statement order in this block.
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      instr_w_q   <= instr_w_d;
      a3_w_q      <= a3_w_d;
      res_w_q     <= res_w_d;
      pc8_w_q     <= pc8_w_d;
      ao_w_q      <= ao_w_d;
      dr_w_q      <= dr_w_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;
  assign instr_w   = instr_w_q;
  assign a3_w      = a3_w_q;
  assign res_w     = res_w_q;
  assign pc8_w     = pc8_w_q;
  assign ao_w      = ao_w_q;
  assign dr_w      = dr_w_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Self-checking bench for mem_access_unit. Each instruction is presented in M
// and walked through its expected cycle sequence; expected bus fields, stall
// behaviour and W contents come from a transaction-level reference model that
// applies the load/store rules with plain arithmetic. Honours
// MEM_ALIGN_CHECK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam logic [5:0] O_LW  = 6'b100011;
  localparam logic [5:0] O_LH  = 6'b100001;
  localparam logic [5:0] O_LHU = 6'b100101;
  localparam logic [5:0] O_LB  = 6'b100000;
  localparam logic [5:0] O_LBU = 6'b100100;
  localparam logic [5:0] O_SW  = 6'b101011;
  localparam logic [5:0] O_SH  = 6'b101001;
  localparam logic [5:0] O_SB  = 6'b101000;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [31:0] instr_m, ao_m, v2_m, pc8_m;
  logic [4:0]  a3_m;
  logic [2:0]  res_m;
  logic        bus_req, bus_we, bus_ack, stall_m, exc_adel, exc_ades;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic [31:0] instr_w, pc8_w, ao_w, dr_w;
  logic [4:0]  a3_w;
  logic [2:0]  res_w;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_unit dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .instr_m   (instr_m),
    .ao_m      (ao_m),
    .v2_m      (v2_m),
    .a3_m      (a3_m),
    .res_m     (res_m),
    .pc8_m     (pc8_m),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .stall_m   (stall_m),
    .instr_w   (instr_w),
    .a3_w      (a3_w),
    .res_w     (res_w),
    .pc8_w     (pc8_w),
    .ao_w      (ao_w),
    .dr_w      (dr_w),
    .exc_adel  (exc_adel),
    .exc_ades  (exc_ades)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic bit m_is_store(input logic [5:0] op);
    return (op == O_SW) || (op == O_SH) || (op == O_SB);
  endfunction

  function automatic bit m_is_load(input logic [5:0] op);
    return (op == O_LW) || (op == O_LH) || (op == O_LHU) || (op == O_LB) || (op == O_LBU);
  endfunction

  function automatic bit m_misaligned(input logic [5:0] op, input logic [31:0] ao);
`ifdef MEM_ALIGN_CHECK_EN
    if (op == O_LW || op == O_SW) return (ao % 4) != 0;
    if (op == O_LH || op == O_LHU || op == O_SH) return (ao % 2) != 0;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] m_be(input logic [5:0] op, input logic [31:0] ao);
    int lane;
    lane = int'(ao % 4);
    if (op == O_SH) return 4'(3 << (2 * (lane / 2)));
    if (op == O_SB) return 4'(1 << lane);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] v2);
    logic [31:0] b, h;
    b = v2 & 32'hFF;
    h = v2 & 32'hFFFF;
    if (op == O_SB) return b * 32'h01010101;
    if (op == O_SH) return h * 32'h00010001;
    return v2;
  endfunction

  function automatic logic [31:0] m_dr(input logic [5:0] op, input logic [31:0] ao,
                                       input logic [31:0] rd);
    logic [31:0] b, h;
    int lane;
    lane = int'(ao % 4);
    b = (rd >> (8 * lane)) & 32'hFF;
    h = (rd >> (16 * (lane / 2))) & 32'hFFFF;
    case (op)
      O_LW:    return rd;
      O_LBU:   return b;
      O_LHU:   return h;
      O_LB:    return (b >= 32'd128)   ? b - 32'd256   : b;
      O_LH:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_w(input string tag, input logic [31:0] ins, input logic [4:0] a3,
                         input logic [2:0] res, input logic [31:0] pc8,
                         input logic [31:0] ao, input logic [31:0] dr);
    check({tag, "_instr_w"}, instr_w, ins);
    check({tag, "_a3_w"}, 32'(a3_w), 32'(a3));
    check({tag, "_res_w"}, 32'(res_w), 32'(res));
    check({tag, "_pc8_w"}, pc8_w, pc8);
    check({tag, "_ao_w"}, ao_w, ao);
    check({tag, "_dr_w"}, dr_w, dr);
  endtask

  // Presents one instruction at a negedge and walks its expected sequence.
  // Returns at a negedge after the op has been written into W.
  task automatic run_op(input logic [5:0] op, input logic [31:0] ao, input logic [31:0] v2,
                        input logic [31:0] rd, input int delay);
    logic [31:0] ins, pc8;
    logic [4:0]  a3;
    logic [2:0]  res;
    bit          ld, st, mis;
    ins = {op, 26'($urandom)};
    a3  = 5'($urandom);
    res = 3'($urandom);
    pc8 = $urandom;
    ld  = m_is_load(op);
    st  = m_is_store(op);
    mis = m_misaligned(op, ao);
    instr_m = ins; ao_m = ao; v2_m = v2; a3_m = a3; res_m = res; pc8_m = pc8;
    bus_ack = 1'($urandom);
    bus_rdata = $urandom;
    #1;
    check("exc_adel", 32'(exc_adel), 32'(ld & mis));
    check("exc_ades", 32'(exc_ades), 32'(st & mis));
    check("idle_req", 32'(bus_req), 32'd0);
    if (!(ld || st) || mis) begin
      check("pass_stall", 32'(stall_m), 32'd0);
      @(posedge clk); @(negedge clk);
      check_w("pass", ins, a3, res, pc8, ao, 32'd0);
    end else begin
      check("idle_stall", 32'(stall_m), 32'd1);
      @(posedge clk); @(negedge clk);
      for (int i = 0; i <= delay; i++) begin
        bus_ack   = (i == delay);
        bus_rdata = (i == delay) ? rd : $urandom;
        #1;
        check("busy_req", 32'(bus_req), 32'd1);
        check("busy_stall", 32'(stall_m), 32'd1);
        check("busy_addr", bus_addr, ao & 32'hFFFF_FFFC);
        check("busy_be", 32'(bus_be), 32'(m_be(op, ao)));
        check("busy_we", 32'(bus_we), 32'(st));
        if (st) check("busy_wdata", bus_wdata, m_wdata(op, v2));
        check("bubble_instr_w", instr_w, 32'd0);
        check("bubble_dr_w", dr_w, 32'd0);
        @(posedge clk); @(negedge clk);
      end
      bus_ack   = 1'($urandom);
      bus_rdata = $urandom;
      #1;
      check("done_stall", 32'(stall_m), 32'd0);
      check("done_req", 32'(bus_req), 32'd0);
      @(posedge clk); @(negedge clk);
      check_w("mem", ins, a3, res, pc8, ao, ld ? m_dr(op, ao, rd) : 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, 32'(bus_req), 32'd0);
    check({tag, "_we"}, 32'(bus_we), 32'd0);
    check({tag, "_addr"}, bus_addr, 32'd0);
    check({tag, "_be"}, 32'(bus_be), 32'd0);
    check({tag, "_wdata"}, bus_wdata, 32'd0);
    check_w(tag, 32'd0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [5:0] mem_ops [8] = '{O_LW, O_LH, O_LHU, O_LB, O_LBU, O_SW, O_SH, O_SB};

  initial begin
    logic [5:0]  op;
    logic [31:0] ao;
    clr_n = 1'b0;
    instr_m = '0; ao_m = '0; v2_m = '0; a3_m = '0; res_m = '0; pc8_m = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    #1;
    check_all_zero("reset");
    check("reset_stall", 32'(stall_m), 32'd0);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;

    // Directed cases
    run_op(O_LW,  32'h10, 32'h1234_5678, 32'hDEAD_BEEF, 0);
    run_op(O_SB,  32'h13, 32'h0000_00A5, 32'h0,         1);
    check("sb_be_const", 32'(bus_be), 32'h8);
    check("sb_wdata_const", bus_wdata, 32'hA5A5_A5A5);
    run_op(O_LB,  32'h2,  32'h0,         32'h0080_0000, 0);
    check("lb_dr_const", dr_w, 32'hFFFF_FF80);
    run_op(O_LBU, 32'h2,  32'h0,         32'h0080_0000, 2);
    check("lbu_dr_const", dr_w, 32'h0000_0080);
    run_op(O_LH,  32'h1,  32'h0,         32'hCAFE_8001, 0);
`ifdef MEM_ALIGN_CHECK_EN
    check("lh_mis_dr_const", dr_w, 32'h0);
`else
    check("lh_half0_dr_const", dr_w, 32'hFFFF_8001);
`endif
    run_op(O_SH,  32'h6,  32'h0000_BEEF, 32'h0,         0);
    run_op(O_SW,  32'h7,  32'h0BAD_F00D, 32'h0,         0);

    // Reset in the middle of a stalled store
    instr_m = {O_SW, 26'h0}; ao_m = 32'h20; v2_m = 32'h5555_AAAA; bus_ack = 1'b0;
    #1;
    check("rst_seq_stall", 32'(stall_m), 32'd1);
    @(posedge clk); @(negedge clk);
    repeat (4) begin
      #1;
      check("rst_seq_busy_req", 32'(bus_req), 32'd1);
      @(posedge clk); @(negedge clk);
    end
    #2;
    clr_n = 1'b0;
    #1;
    check_all_zero("midbusy_rst");
    instr_m = 32'h0;
    #1;
    check("midbusy_rst_idle", 32'(stall_m), 32'd0);
    @(negedge clk);
    check("rst_hold_instr_w", instr_w, 32'd0);
    clr_n = 1'b1;
    run_op(6'b001000, 32'h40, 32'h0, 32'h0, 0);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) < 7) begin
        op = mem_ops[$urandom_range(0, 7)];
      end else begin
        op = 6'($urandom);
        while (m_is_load(op) || m_is_store(op)) op = 6'($urandom);
      end
      ao = $urandom;
      run_op(op, ao, $urandom, $urandom, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
